// File: rtl/dma_mc_engine.sv
// Multi-channel DMA engine. Each channel holds a byte count. Channels are
// granted one at a time in round-robin order. A granted channel moves data
// in bursts of fetch/deposit beat pairs through an external FIFO.
module dma_mc_engine #(
  parameter int NCH        = 2,
  parameter int BEAT_BYTES = 4,
  parameter int BURST      = 4,
  parameter int SW         = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NCH-1:0]                        start,
  input  logic [NCH*SW-1:0]                     size,
  input  logic                                  fifo_full,
  input  logic                                  fifo_empty,
  output logic                                  fifo_wr_en,
  output logic                                  fifo_rd_en,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_sel,
  output logic [NCH-1:0]                        ch_busy,
  output logic [NCH-1:0]                        done,
  output logic                                  busy
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DEPOSIT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SW-1:0]  size_q  [NCH];
  logic [SW-1:0]  count_q [NCH];
  logic [NCH-1:0] ch_busy_q;
  logic [NCH-1:0] done_q;
  logic [CW-1:0]  ch_sel_q;
  logic [CW-1:0]  rr_ptr_q;
  logic [BW-1:0]  burst_q;
  logic [BW-1:0]  burst_nx;

  logic           grant_vld;
  logic [CW-1:0]  grant_idx;
  logic [CW-1:0]  rr_nx;
  logic           grant_take;
  logic           beat;
  logic           cur_last;

  // The sum is one bit wider than the count so a count near the top of its
  // range cannot wrap and miss the end. A partial final beat still counts as
  // a whole beat, so a size that is not a multiple of BEAT_BYTES rounds up.
  function automatic logic last_beat(input logic [SW-1:0] cnt,
                                     input logic [SW-1:0] sz);
    logic [SW:0] sum;
    sum = {1'b0, cnt} + (SW+1)'(BEAT_BYTES);
    return (sum >= {1'b0, sz});
  endfunction

  assign burst_nx = burst_q + 1'b1;
  assign cur_last = last_beat(count_q[ch_sel_q], size_q[ch_sel_q]);

  // Round-robin search: first busy channel at or after the pointer, wrapping.
  always_comb begin
    int j;
    int n;
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_nx     = '0;
    j         = 0;
    n         = 0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NCH) j = j - NCH;
      if (!grant_vld && ch_busy_q[j]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(j);
      end
    end
    n = int'(grant_idx) + 1;
    if (n >= NCH) n = 0;
    rr_nx = CW'(n);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the FIFO strobes. The strobes decode directly from
  // state, so a write and a read can never be asserted in the same cycle.
  always_comb begin
    state_d    = state_q;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    grant_take = 1'b0;
    beat       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          grant_take = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          state_d    = DEPOSIT;
        end
      end
      DEPOSIT: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          beat       = 1'b1;
          if (cur_last)                    state_d = IDLE;
          else if (burst_nx == BW'(BURST)) state_d = IDLE;
          else                             state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel bookkeeping: grant capture, beat accounting, start acceptance.
  // A start can only be accepted on an idle channel, and a beat only ever
  // lands on a busy channel, so the two never touch the same channel in one
  // cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        size_q[i]  <= '0;
        count_q[i] <= '0;
      end
      ch_busy_q <= '0;
      done_q    <= '0;
      ch_sel_q  <= '0;
      rr_ptr_q  <= '0;
      burst_q   <= '0;
    end else begin
      done_q <= '0;
      if (grant_take) begin
        ch_sel_q <= grant_idx;
        rr_ptr_q <= rr_nx;
        burst_q  <= '0;
      end
      if (beat) begin
        count_q[ch_sel_q] <= count_q[ch_sel_q] + SW'(BEAT_BYTES);
        burst_q           <= burst_nx;
        if (cur_last) begin
          done_q[ch_sel_q]    <= 1'b1;
          ch_busy_q[ch_sel_q] <= 1'b0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (start[i] && !ch_busy_q[i]) begin
          size_q[i]  <= size[i*SW +: SW];
          count_q[i] <= '0;
          if (size[i*SW +: SW] != '0) ch_busy_q[i] <= 1'b1;
          else                        done_q[i]    <= 1'b1;
        end
      end
    end
  end

  assign ch_busy = ch_busy_q;
  assign done    = done_q;
  assign ch_sel  = ch_sel_q;
  assign busy    = |ch_busy_q;

endmodule

// File: tb/tb_dma_mc_engine.sv
// Directed bench for dma_mc_engine at NCH=2, BEAT_BYTES=4, BURST=4, SW=32.
module tb_dma_mc_engine;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start;
  logic [63:0] size;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_wr_en;
  logic        fifo_rd_en;
  logic [0:0]  ch_sel;
  logic [1:0]  ch_busy;
  logic [1:0]  done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  dma_mc_engine #(
    .NCH(2), .BEAT_BYTES(4), .BURST(4), .SW(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .size       (size),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .ch_sel     (ch_sel),
    .ch_busy    (ch_busy),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = '0;
    size       = '0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Counts strobes from the current cycle until done[ch] is seen.
  task automatic run_until_done(input int ch, input int max_cyc,
                                output int nwr, output int nrd,
                                output int ovl, output logic to);
    nwr = 0; nrd = 0; ovl = 0; to = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (fifo_wr_en) nwr++;
      if (fifo_rd_en) nrd++;
      if (fifo_wr_en && fifo_rd_en) ovl++;
      if (done[ch]) begin
        to = 1'b0;
        return;
      end
      tick();
    end
  endtask

  initial begin
    int   nwr, nrd, ovl, dcnt, n, d0, d1;
    logic to;
    int   sel_log [32];

    // Reset state
    do_reset();
    check("rst_wr", fifo_wr_en, 0);
    check("rst_rd", fifo_rd_en, 0);
    check("rst_busy", ch_busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", ch_sel, 0);

    // size 8 on ch0: two alternating beat pairs, one done
    do_reset();
    size[31:0] = 32'd8; start = 2'b01;
    tick(); start = 2'b00;
    check("s8_busy_set", ch_busy, 2'b01);
    check("s8_busy_or", busy, 1);
    check("s8_idle_wr", fifo_wr_en, 0);
    tick();
    check("s8_f1_wr", fifo_wr_en, 1);
    check("s8_f1_rd", fifo_rd_en, 0);
    check("s8_f1_sel", ch_sel, 0);
    tick();
    check("s8_d1_rd", fifo_rd_en, 1);
    check("s8_d1_wr", fifo_wr_en, 0);
    tick();
    check("s8_f2_wr", fifo_wr_en, 1);
    tick();
    check("s8_d2_rd", fifo_rd_en, 1);
    tick();
    check("s8_done", done, 2'b01);
    check("s8_busy_clr", ch_busy, 0);
    check("s8_busy_or_clr", busy, 0);
    check("s8_done_wr", fifo_wr_en, 0);
    tick();
    check("s8_done_pulse", done, 0);

    // size 10 rounds up to 3 beats
    do_reset();
    size[31:0] = 32'd10; start = 2'b01;
    tick(); start = 2'b00;
    run_until_done(0, 100, nwr, nrd, ovl, to);
    check("s10_to", to, 0);
    check("s10_wr", nwr, 3);
    check("s10_rd", nrd, 3);
    check("s10_ovl", ovl, 0);
    // restart accepted in the same cycle as done
    size[31:0] = 32'd4; start = 2'b01;
    tick(); start = 2'b00;
    check("rst_on_done_busy", ch_busy, 2'b01);
    run_until_done(0, 100, nwr, nrd, ovl, to);
    check("rst_on_done_to", to, 0);
    check("rst_on_done_rd", nrd, 1);

    // Both channels, size 32: bursts of 4 alternate ch0,ch1,ch0,ch1
    do_reset();
    size = {32'd32, 32'd32}; start = 2'b11;
    tick(); start = 2'b00;
    n = 0; d0 = -1; d1 = -1;
    for (int c = 0; c < 300; c++) begin
      if (fifo_wr_en && n < 32) begin
        sel_log[n] = int'(ch_sel);
        n++;
      end
      if (done[0] && d0 < 0) d0 = c;
      if (done[1] && d1 < 0) d1 = c;
      if (d1 >= 0) break;
      tick();
    end
    check("rr_beats", n, 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("rr_sel%0d", k), sel_log[k], (k / 4) % 2);
    check("rr_d0_seen", (d0 >= 0), 1);
    check("rr_d0_first", (d0 >= 0 && d0 < d1), 1);

    // fifo_full for 3 FETCH cycles
    do_reset();
    size[31:0] = 32'd8; start = 2'b01;
    tick(); start = 2'b00;
    tick();
    fifo_full = 1'b1; #1;
    check("full_c1_wr", fifo_wr_en, 0);
    tick();
    check("full_c2_wr", fifo_wr_en, 0);
    check("full_c2_rd", fifo_rd_en, 0);
    tick();
    check("full_c3_wr", fifo_wr_en, 0);
    fifo_full = 1'b0; #1;
    check("full_rel_wr", fifo_wr_en, 1);
    run_until_done(0, 100, nwr, nrd, ovl, to);
    check("full_to", to, 0);
    check("full_wr", nwr, 2);
    check("full_rd", nrd, 2);

    // size 0: done next cycle, no strobes
    do_reset();
    size[31:0] = 32'd0; start = 2'b01;
    tick(); start = 2'b00;
    check("z_done", done, 2'b01);
    check("z_busy", ch_busy, 0);
    check("z_wr", fifo_wr_en, 0);
    check("z_rd", fifo_rd_en, 0);
    tick();
    check("z_done_clr", done, 0);
    tick();
    check("z_no_wr", fifo_wr_en, 0);

    // start held high while busy is ignored
    do_reset();
    size[31:0] = 32'd8; start = 2'b01;
    tick();
    size[31:0] = 32'd100;
    run_until_done(0, 100, nwr, nrd, ovl, to);
    start = 2'b00;
    check("rep_to", to, 0);
    check("rep_wr", nwr, 2);
    check("rep_rd", nrd, 2);
    dcnt = 0;
    repeat (10) begin
      tick();
      if (done[0]) dcnt++;
    end
    check("rep_single_done", dcnt, 0);
    check("rep_idle", busy, 0);

    // reset mid-transfer after 2 beats, then a fresh ch1 transfer
    do_reset();
    size[31:0] = 32'd32; start = 2'b01;
    tick(); start = 2'b00;
    repeat (5) tick();
    check("mid_pos_wr", fifo_wr_en, 1);
    rst_n = 1'b0; #1;
    check("mid_wr", fifo_wr_en, 0);
    check("mid_rd", fifo_rd_en, 0);
    check("mid_busy", ch_busy, 0);
    check("mid_busy_or", busy, 0);
    check("mid_done", done, 0);
    check("mid_sel", ch_sel, 0);
    dcnt = 0;
    repeat (3) begin
      tick();
      if (done != 0) dcnt++;
    end
    check("mid_no_done", dcnt, 0);
    rst_n = 1'b1;
    size[63:32] = 32'd4; start = 2'b10;
    tick(); start = 2'b00;
    run_until_done(1, 100, nwr, nrd, ovl, to);
    check("post_to", to, 0);
    check("post_wr", nwr, 1);
    check("post_rd", nrd, 1);
    check("post_sel", ch_sel, 1);
    check("post_busy0", ch_busy[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dma_mc_engine.md
DMA_MC_ENGINE -- requirements
Module: dma_mc_engine

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent DMA channels (1..8).
REQ-002 SHALL have parameter BEAT_BYTES, default 4: bytes moved per FIFO beat.
REQ-003 SHALL have parameter BURST, default 4: maximum beats per grant before re-arbitration.
REQ-004 SHALL have parameter SW, default 32: width of each size/count field.
REQ-005 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  start  in  NCH  per-channel start request, sampled each clk.
  size  in  NCH*SW  per-channel byte count; channel i at bits [i*SW +: SW].
  fifo_full  in  1  FIFO cannot accept a write this cycle.
  fifo_empty  in  1  FIFO cannot supply a read this cycle.
  fifo_wr_en  out  1  fetch beat strobe.
  fifo_rd_en  out  1  deposit beat strobe.
  ch_sel  out  $clog2(NCH) (min 1)  currently granted channel.
  ch_busy  out  NCH  per-channel busy.
  done  out  NCH  per-channel one-cycle completion pulse.
  busy  out  1  OR of ch_busy.

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, DEPOSIT.
REQ-007 Start accept: start[i]=1 with ch_busy[i]=0 SHALL latch size[i] and clear count[i] to 0.
  - If the latched size is nonzero: ch_busy[i]=1 from the next cycle.
  - If the latched size is 0: done[i]=1 for exactly the next cycle; ch_busy[i] stays 0; no FIFO strobes.
REQ-008 start[i] while ch_busy[i]=1 SHALL be ignored.
REQ-009 IDLE, arbitration: if any ch_busy bit is set, SHALL grant in round-robin order beginning at (last granted + 1) mod NCH.
  - Grant: register ch_sel and clear the burst beat counter; go to FETCH next cycle.
  - After reset, the search starts at channel 0.
REQ-010 FETCH: fifo_wr_en = (state==FETCH) && !fifo_full, combinational.
  - !fifo_full: go to DEPOSIT.
  - fifo_full: stay in FETCH; no counter change.
REQ-011 DEPOSIT: fifo_rd_en = (state==DEPOSIT) && !fifo_empty, combinational.
  - fifo_empty: stay in DEPOSIT; no counter change.
  - !fifo_empty: count[ch_sel] += BEAT_BYTES and burst counter += 1.
REQ-012 Beat completion:
  - Last beat (count + BEAT_BYTES >= size): done[ch_sel]=1 and ch_busy[ch_sel]=0 at the next edge; go to IDLE.
  - Else if burst counter reaches BURST: go to IDLE to re-arbitrate.
  - Else: go to FETCH.
REQ-013 The last-beat compare SHALL use SW+1-bit arithmetic so that count + BEAT_BYTES cannot wrap.
  - size not a multiple of BEAT_BYTES rounds up to whole beats.
REQ-014 fifo_wr_en and fifo_rd_en SHALL never be high in the same cycle.
REQ-015 start[i] arriving in the same cycle that done[i]=1 SHALL be accepted.
REQ-016 start on a channel other than ch_sel SHALL NOT disturb the active transfer.
REQ-017 busy SHALL equal |ch_busy.

Reset
REQ-018 rst_n=0 SHALL asynchronously force:
  - state=IDLE.
  - fifo_wr_en, fifo_rd_en, ch_busy, done, busy, ch_sel = 0.
  - All count, size and burst registers = 0.
  - Round-robin pointer = channel 0.
REQ-019 Reset mid-transfer SHALL abandon all channels with no done pulse; operation resumes on the first clk after rst_n=1.

Verification (NCH=2, BEAT_BYTES=4, BURST=4; FIFO never full/empty unless stated)
REQ-020 start[0], size0=8 -> exactly 2 wr/rd strobe pairs alternating; done[0] pulses once; ch_busy[0] and busy return to 0.
REQ-021 size0=10 -> 3 beats (count 0,4,8); done[0] after the 3rd rd strobe.
REQ-022 start[0]=start[1] in the same cycle, both size 32 -> grants ch0, ch1, ch0, ch1 with 4 beats each; done[0] precedes done[1].
REQ-023 fifo_full=1 for 3 cycles during FETCH -> fifo_wr_en low for those 3 cycles; count unchanged; transfer completes with correct beat total.
REQ-024 Edge cases: size0=0 -> done[0] one cycle later, no FIFO strobes; start[0] repeated while busy -> ignored, single done.
REQ-025 rst_n low after 2 beats of a size-32 transfer -> all outputs 0 immediately, no done; a new start[1] size 4 afterwards completes in 1 beat.
